// File: rtl/gradient_mag_angle_pipe.sv
// Gradient magnitude / direction pipeline.
// Takes a signed Sobel (Gx, Gy) pair per pixel and produces a saturated,
// thresholded magnitude plus a 4-bin direction code. Three register stages
// with a single global advance enable; a saturating count of non-zero
// output pixels is kept per frame.
module gradient_mag_angle_pipe #(
  parameter int BITS      = 9,
  parameter int PRECISION = 8,
  parameter int CNT_BITS  = 20
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [BITS-1:0]      in_x,
  input  logic signed [BITS-1:0]      in_y,
  input  logic                        mag_mode,
  input  logic        [PRECISION-1:0] thresh,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic        [PRECISION-1:0] out_mag,
  output logic        [1:0]           out_angle,
  input  logic                        clear_count,
  output logic        [CNT_BITS-1:0]  edge_count
);

  localparam int STAGES = 3;
  localparam int RW     = BITS + 1;            // raw magnitude width
  localparam int CW     = BITS + 2;            // angle comparison width
  localparam int SH     = BITS - 1 - PRECISION;
  localparam logic [BITS-1:0] ONE_B = BITS'(1);
  localparam logic [RW-1:0]   MAXV  = RW'((1 << PRECISION) - 1);

  typedef struct packed {
    logic [BITS-1:0]      ax;
    logic [BITS-1:0]      ay;
    logic                 sx;
    logic                 sy;
    logic                 mode;
    logic [PRECISION-1:0] th;
  } s1_t;

  typedef struct packed {
    logic [RW-1:0]        raw;
    logic                 horiz;   // ay*2.5 <= ax
    logic                 diag;    // ay <= ax*2.5
    logic                 same;    // signs of Gx and Gy agree
    logic [PRECISION-1:0] th;
  } s2_t;

  logic [STAGES:1]      vld_pipe;
  logic                 en;
  s1_t                  s1_d, s1_q;
  s2_t                  s2_d, s2_q;
  logic [PRECISION-1:0] mag_n;
  logic [1:0]           ang_n;

  // Whole pipe advances together; a full output slot blocks everything.
  assign en        = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];

  // -2^(BITS-1) negates to 2^(BITS-1), which still fits as unsigned.
  function automatic logic [BITS-1:0] abs_v(input logic [BITS-1:0] v);
    return v[BITS-1] ? ((~v) + ONE_B) : v;
  endfunction

  // S1 inputs: magnitudes, signs and per-pixel controls.
  always_comb begin
    s1_d      = '0;
    s1_d.ax   = abs_v(in_x);
    s1_d.ay   = abs_v(in_y);
    s1_d.sx   = in_x[BITS-1];
    s1_d.sy   = in_y[BITS-1];
    s1_d.mode = mag_mode;
    s1_d.th   = thresh;
  end

  // S2 inputs: raw magnitude in either mode and the direction comparisons.
  always_comb begin
    logic [RW-1:0] ax_w, ay_w, mx, mn;
    logic [CW-1:0] ax_c, ay_c;
    ax_w = {1'b0, s1_q.ax};
    ay_w = {1'b0, s1_q.ay};
    mx   = (ax_w >= ay_w) ? ax_w : ay_w;
    mn   = (ax_w >= ay_w) ? ay_w : ax_w;
    ax_c = {2'b00, s1_q.ax};
    ay_c = {2'b00, s1_q.ay};
    s2_d       = '0;
    s2_d.raw   = s1_q.mode ? (mx + (mn >> 2)) : ((ax_w + ay_w) >> 1);
    s2_d.horiz = ((ay_c << 1) + (ay_c >> 1)) <= ax_c;
    s2_d.diag  = ay_c <= ((ax_c << 1) + (ax_c >> 1));
    s2_d.same  = s1_q.sx == s1_q.sy;
    s2_d.th    = s1_q.th;
  end

  // S3 inputs: scale, saturate, threshold, pick the direction bin.
  always_comb begin
    logic [RW-1:0]        scaled;
    logic [PRECISION-1:0] m;
    scaled = s2_q.raw >> SH;
    m      = (scaled > MAXV) ? '1 : scaled[PRECISION-1:0];
    mag_n  = (m < s2_q.th) ? '0 : m;
    ang_n  = s2_q.horiz ? 2'd0 : (s2_q.diag ? (s2_q.same ? 2'd1 : 2'd3) : 2'd2);
  end

  // Valid shift register and internal data stages, all gated by en.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      s1_q     <= s1_d;
      s2_q     <= s2_d;
    end
  end

  // Output data only loads on a real pixel so it stays 0 until the first one.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_mag   <= '0;
      out_angle <= '0;
    end else if (en && vld_pipe[STAGES-1]) begin
      out_mag   <= mag_n;
      out_angle <= ang_n;
    end
  end

  // Saturating edge counter; clear wins over a coincident increment.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      edge_count <= '0;
    else if (clear_count)
      edge_count <= '0;
    else if (out_valid && out_ready && (out_mag != '0) && (edge_count != '1))
      edge_count <= edge_count + CNT_BITS'(1);
  end

endmodule

// File: tb/tb_gradient_mag_angle_pipe.sv
// Directed bench for gradient_mag_angle_pipe (BITS=9, PRECISION=8).
module tb_gradient_mag_angle_pipe;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [8:0] in_x = '0;
  logic signed [8:0] in_y = '0;
  logic              mag_mode = 1'b0;
  logic [7:0]        thresh = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [7:0]        out_mag;
  logic [1:0]        out_angle;
  logic              clear_count = 1'b0;
  logic [19:0]       edge_count;

  int errors = 0;
  int checks = 0;

  gradient_mag_angle_pipe #(.BITS(9), .PRECISION(8), .CNT_BITS(20)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .mag_mode(mag_mode), .thresh(thresh),
    .out_valid(out_valid), .out_ready(out_ready), .out_mag(out_mag),
    .out_angle(out_angle), .clear_count(clear_count), .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Single isolated pixel with out_ready high: checks latency, data, count.
  task automatic one_pixel(input string tag, input int x, input int y, input logic m,
                           input int th, input int emag, input int eang, input int ecnt);
    @(negedge clk);
    in_x = 9'(x); in_y = 9'(y); mag_mode = m; thresh = 8'(th); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, 32'(out_valid), 0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_mag"},   32'(out_mag),   32'(emag));
    chk({tag, "_ang"},   32'(out_angle), 32'(eang));
    @(negedge clk);
    chk({tag, "_cnt"},   32'(edge_count), 32'(ecnt));
  endtask

  int sxv [6] = '{100, -256, -50,  10, 0,  30};
  int syv [6] = '{ 20, -256,  50, 200, 0, -40};
  logic smd [6] = '{0, 0, 1, 0, 0, 1};
  int smag[6] = '{ 60,  255,  62, 105, 0,  47};
  int sang[6] = '{  0,    1,   3,   2, 0,   3};

  initial begin
    int si, oi;
    // reset state
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_mag",   32'(out_mag),   0);
    chk("rst_ang",   32'(out_angle), 0);
    chk("rst_cnt",   32'(edge_count), 0);
    chk("rst_ready", 32'(in_ready),  1);
    @(negedge clk);
    n_rst = 1'b1;

    one_pixel("p_100_20",    100,   20, 1'b0,  0,  60, 0, 1);
    one_pixel("p_sat",      -256, -256, 1'b0,  0, 255, 1, 2);
    one_pixel("p_m1_diag",   -50,   50, 1'b1,  0,  62, 3, 3);
    one_pixel("p_vert",       10,  200, 1'b0,  0, 105, 2, 4);
    one_pixel("p_zero",        0,    0, 1'b0,  0,   0, 0, 4);
    one_pixel("p_thr70",     100,   20, 1'b0, 70,   0, 0, 4);
    one_pixel("p_thr60",     100,   20, 1'b0, 60,  60, 0, 5);
    one_pixel("p_m1_sat",      0, -256, 1'b1,  0, 255, 2, 6);

    // 6-pixel stream with a 5-cycle downstream stall
    thresh = 8'd0;
    si = 0; oi = 0;
    for (int cyc = 0; cyc < 40 && oi < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc < 8);
      #1;
      if (!out_ready) begin
        chk("stall_ready", 32'(in_ready),  0);
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_mag",   32'(out_mag),   32'(smag[oi]));
        chk("stall_ang",   32'(out_angle), 32'(sang[oi]));
      end else if (out_valid) begin
        chk("stream_mag", 32'(out_mag),   32'(smag[oi]));
        chk("stream_ang", 32'(out_angle), 32'(sang[oi]));
        oi++;
      end
      if (si < 6) begin
        in_valid = 1'b1; in_x = 9'(sxv[si]); in_y = 9'(syv[si]); mag_mode = smd[si];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) si++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_delivered", 32'(oi), 6);
    @(negedge clk);
    chk("stream_cnt", 32'(edge_count), 11);
    chk("stream_drained", 32'(out_valid), 0);

    // clear_count coincident with a non-zero handshake
    @(negedge clk);
    in_x = 9'(100); in_y = 9'(20); mag_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("clr_valid", 32'(out_valid), 1);
    clear_count = 1'b1;
    @(negedge clk);
    clear_count = 1'b0;
    chk("clr_cnt", 32'(edge_count), 0);

    // asynchronous reset with pixels in flight
    @(negedge clk);
    in_x = 9'(100); in_y = 9'(20); mag_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_x = 9'(10); in_y = 9'(200);
    @(negedge clk);
    in_x = -9'sd50; in_y = 9'(50); mag_mode = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 1);
    chk("pre_rst_mag",   32'(out_mag),   60);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid),  0);
    chk("arst_mag",   32'(out_mag),    0);
    chk("arst_ang",   32'(out_angle),  0);
    chk("arst_cnt",   32'(edge_count), 0);
    chk("arst_ready", 32'(in_ready),   1);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_stale", 32'(out_valid), 0);
    end
    one_pixel("post_rst", -256, 0, 1'b0, 0, 128, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
